// File: rtl/sram_write_ctrl_if.sv
// Bus bundle between the write arbiter, packet SRAM, queue manager and read-side
// release path for sram_write_ctrl.
interface sram_write_ctrl_if #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_PORTS  = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 16
);
  localparam int PORT_W = $clog2(NUM_PORTS);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [PORT_W-1:0]     in_port;
  logic                  in_sop;
  logic                  in_eop;
  logic                  sram_wr_en;
  logic [ADDR_WIDTH-1:0] sram_wr_addr;
  logic [DATA_WIDTH-1:0] sram_wr_data;
  logic                  desc_valid;
  logic                  desc_ready;
  logic [PORT_W-1:0]     desc_port;
  logic [ADDR_WIDTH-1:0] desc_head;
  logic [ADDR_WIDTH-1:0] desc_tail;
  logic [LEN_WIDTH-1:0]  desc_len;
  logic                  rel_valid;
  logic [ADDR_WIDTH-1:0] rel_addr;
  logic [ADDR_WIDTH-1:0] lnk_rd_addr;
  logic [ADDR_WIDTH-1:0] lnk_rd_data;
  logic [ADDR_WIDTH:0]   free_cnt;
  logic                  init_done;
  logic                  err;

  modport slave (
    input  in_valid, in_data, in_port, in_sop, in_eop, desc_ready,
           rel_valid, rel_addr, lnk_rd_addr,
    output in_ready, sram_wr_en, sram_wr_addr, sram_wr_data, desc_valid,
           desc_port, desc_head, desc_tail, desc_len, lnk_rd_data,
           free_cnt, init_done, err
  );

  modport master (
    output in_valid, in_data, in_port, in_sop, in_eop, desc_ready,
           rel_valid, rel_addr, lnk_rd_addr,
    input  in_ready, sram_wr_en, sram_wr_addr, sram_wr_data, desc_valid,
           desc_port, desc_head, desc_tail, desc_len, lnk_rd_data,
           free_cnt, init_done, err
  );
endinterface

// File: rtl/sram_write_ctrl.sv
// Write-side packet SRAM controller: free-list allocation per beat, beat linking,
// and one descriptor per packet toward the queue manager.
module sram_write_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_PORTS  = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  sram_write_ctrl_if.slave  bus
);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PKT} state_t;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [PORT_W-1:0]     port_q, port_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  dv_q, dv_d;
  logic [PORT_W-1:0]     dport_q, dport_d;
  logic [ADDR_WIDTH-1:0] dhead_q, dhead_d, dtail_q, dtail_d;
  logic [LEN_WIDTH-1:0]  dlen_q, dlen_d;
  logic [ADDR_WIDTH-1:0] lnk_rd_q, lnk_rd_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] fl_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] lnk_mem [DEPTH];
  logic                  fl_we, lnk_we;
  logic [ADDR_WIDTH-1:0] fl_waddr, fl_wdata, lnk_waddr, lnk_wdata;

  logic                  in_ready, accept, pop, push;
  logic [ADDR_WIDTH-1:0] alloc_addr;

  assign in_ready   = (state_q != ST_INIT) && (cnt_q != '0) && !dv_q;
  assign accept     = bus.in_valid && in_ready;
  assign alloc_addr = fl_mem[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    len_d     = len_q;
    port_d    = port_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    dv_d      = dv_q;
    dport_d   = dport_q;
    dhead_d   = dhead_q;
    dtail_d   = dtail_q;
    dlen_d    = dlen_q;
    lnk_rd_d  = lnk_mem[bus.lnk_rd_addr];
    err_d     = 1'b0;
    fl_we     = 1'b0;
    fl_waddr  = wr_ptr_q;
    fl_wdata  = bus.rel_addr;
    lnk_we    = 1'b0;
    lnk_waddr = tail_q;
    lnk_wdata = alloc_addr;
    pop       = 1'b0;
    push      = 1'b0;

    if (dv_q && bus.desc_ready) dv_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Seed entry i with address i; releases are not accepted yet.
        fl_we    = 1'b1;
        fl_wdata = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (bus.rel_valid) err_d = 1'b1;
        if (wr_ptr_q == LAST_IDX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_sop) begin
            pop    = 1'b1;
            head_d = alloc_addr;
            tail_d = alloc_addr;
            len_d  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            port_d = bus.in_port;
            if (bus.in_eop) begin
              dv_d    = 1'b1;
              dport_d = bus.in_port;
              dhead_d = alloc_addr;
              dtail_d = alloc_addr;
              dlen_d  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              state_d = ST_PKT;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PKT: begin
        if (accept) begin
          pop    = 1'b1;
          lnk_we = 1'b1;
          tail_d = alloc_addr;
          len_d  = sat_inc(len_q);
          if (bus.in_sop) err_d = 1'b1;
          if (bus.in_eop) begin
            dv_d    = 1'b1;
            dport_d = port_q;
            dhead_d = head_q;
            dtail_d = alloc_addr;
            dlen_d  = sat_inc(len_q);
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (state_q != ST_INIT && bus.rel_valid) begin
      if (cnt_q == FULL_CNT) begin
        err_d = 1'b1;
      end else begin
        push     = 1'b1;
        fl_we    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      wr_en_d   = 1'b1;
      wr_addr_d = alloc_addr;
      wr_data_d = bus.in_data;
    end

    if (state_q != ST_INIT) begin
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      len_q     <= '0;
      port_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dv_q      <= 1'b0;
      dport_q   <= '0;
      dhead_q   <= '0;
      dtail_q   <= '0;
      dlen_q    <= '0;
      lnk_rd_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      len_q     <= len_d;
      port_q    <= port_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      dv_q      <= dv_d;
      dport_q   <= dport_d;
      dhead_q   <= dhead_d;
      dtail_q   <= dtail_d;
      dlen_q    <= dlen_d;
      lnk_rd_q  <= lnk_rd_d;
      err_q     <= err_d;
    end
  end

  // Storage arrays carry no reset; their contents are rebuilt or don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && fl_we)  fl_mem[fl_waddr]   <= fl_wdata;
    if (!rst && lnk_we) lnk_mem[lnk_waddr] <= lnk_wdata;
  end

  assign bus.in_ready     = in_ready;
  assign bus.sram_wr_en   = wr_en_q;
  assign bus.sram_wr_addr = wr_addr_q;
  assign bus.sram_wr_data = wr_data_q;
  assign bus.desc_valid   = dv_q;
  assign bus.desc_port    = dport_q;
  assign bus.desc_head    = dhead_q;
  assign bus.desc_tail    = dtail_q;
  assign bus.desc_len     = dlen_q;
  assign bus.lnk_rd_data  = lnk_rd_q;
  assign bus.free_cnt     = cnt_q;
  assign bus.init_done    = (state_q != ST_INIT);
  assign bus.err          = err_q;
endmodule
